// File: rtl/mem_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream until ack, feeds WB.
// Optional request timeout enabled by defining MEM_TIMEOUT_EN.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ALU_result_MEM,
    input  logic [31:0] Read_Data_2_MEM,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic        MemToReg_MEM,
    input  logic        RegWrite_MEM,
    input  logic        Branch_MEM,
    input  logic        Zero_MEM,
    input  logic [4:0]  Write_register_MEM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_MEM,
    output logic        PCSrc_MEM,
    output logic [31:0] Write_data_WB,
    output logic [4:0]  Write_register_WB,
    output logic        RegWrite_WB,
    output logic        align_err,
    output logic        bus_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic        dmem_req_q, dmem_req_d;
    logic        dmem_we_q, dmem_we_d;
    logic [31:0] dmem_addr_q, dmem_addr_d;
    logic [31:0] dmem_wdata_q, dmem_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic        wb_rw_q, wb_rw_d;
    logic        align_err_q, align_err_d;
    logic        mem_access, misaligned, memop, wb_drop;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic             timed_out_q, timed_out_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign mem_access = MemRead_MEM | MemWrite_MEM;
    assign misaligned = mem_access & (ALU_result_MEM[1:0] != 2'b00);
    assign memop      = mem_access & (ALU_result_MEM[1:0] == 2'b00);
    assign stall_MEM  = ((state_q == S_IDLE) & memop) | (state_q == S_REQ);
    assign PCSrc_MEM  = Branch_MEM & Zero_MEM;

    always_comb begin
        state_d      = state_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        rdata_d      = rdata_q;
        wb_data_d    = wb_data_q;
        wb_reg_d     = wb_reg_q;
        wb_rw_d      = wb_rw_q;
        align_err_d  = (state_q == S_IDLE) & misaligned;
        wb_drop      = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d        = cnt_q;
        bus_err_d    = bus_err_q;
        timed_out_d  = timed_out_q;
        wb_drop      = (state_q == S_DONE) & timed_out_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (memop) begin
                    state_d      = S_REQ;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = MemWrite_MEM;
                    dmem_addr_d  = ALU_result_MEM;
                    dmem_wdata_d = Read_Data_2_MEM;
`ifdef MEM_TIMEOUT_EN
                    cnt_d        = '0;
                    timed_out_d  = 1'b0;
`endif
                end
            end
            S_REQ: begin
                if (dmem_ack) begin
                    state_d    = S_DONE;
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    rdata_d    = dmem_rdata;
                end
`ifdef MEM_TIMEOUT_EN
                // Ack on the limit cycle takes priority over the abort.
                else if (cnt_q == CNT_LIM) begin
                    state_d     = S_DONE;
                    dmem_req_d  = 1'b0;
                    dmem_we_d   = 1'b0;
                    rdata_d     = '0;
                    bus_err_d   = 1'b1;
                    timed_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (stall_MEM) begin
            wb_rw_d = 1'b0;
        end else begin
            wb_reg_d  = Write_register_MEM;
            wb_rw_d   = RegWrite_MEM & ~misaligned & ~wb_drop;
            wb_data_d = MemToReg_MEM ? rdata_q : ALU_result_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            rdata_q      <= '0;
            wb_data_q    <= '0;
            wb_reg_q     <= '0;
            wb_rw_q      <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            rdata_q      <= rdata_d;
            wb_data_q    <= wb_data_d;
            wb_reg_q     <= wb_reg_d;
            wb_rw_q      <= wb_rw_d;
            align_err_q  <= align_err_d;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
            timed_out_q <= timed_out_d;
        end
    end
    assign bus_err = bus_err_q;
`else
    assign bus_err = 1'b0;
`endif

    assign dmem_req          = dmem_req_q;
    assign dmem_we           = dmem_we_q;
    assign dmem_addr         = dmem_addr_q;
    assign dmem_wdata        = dmem_wdata_q;
    assign Write_data_WB     = wb_data_q;
    assign Write_register_WB = wb_reg_q;
    assign RegWrite_WB       = wb_rw_q;
    assign align_err         = align_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table for single-cycle ops, scripted memory transactions,
// WB results tracked through a scoreboard queue.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALU_result_MEM, Read_Data_2_MEM, dmem_rdata;
    logic        MemRead_MEM, MemWrite_MEM, MemToReg_MEM, RegWrite_MEM;
    logic        Branch_MEM, Zero_MEM, dmem_ack;
    logic [4:0]  Write_register_MEM;
    logic        dmem_req, dmem_we, stall_MEM, PCSrc_MEM, RegWrite_WB, align_err, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, Write_data_WB;
    logic [4:0]  Write_register_WB;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .ALU_result_MEM(ALU_result_MEM), .Read_Data_2_MEM(Read_Data_2_MEM),
        .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
        .MemToReg_MEM(MemToReg_MEM), .RegWrite_MEM(RegWrite_MEM),
        .Branch_MEM(Branch_MEM), .Zero_MEM(Zero_MEM),
        .Write_register_MEM(Write_register_MEM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_MEM(stall_MEM), .PCSrc_MEM(PCSrc_MEM),
        .Write_data_WB(Write_data_WB), .Write_register_WB(Write_register_WB),
        .RegWrite_WB(RegWrite_WB), .align_err(align_err), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        chk_data;
    } wb_t;

    typedef struct {
        logic [31:0] alu;
        logic        mrd, mwr, m2r, rw, br, zero;
        logic [4:0]  rd;
        logic        exp_pcsrc, exp_align, exp_rw, chk_data;
    } vec_t;

    wb_t  sb[$];
    vec_t tbl[7];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        wb_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_sb: queue empty, got none want entry", tag);
        end else begin
            e = sb.pop_front();
            if (e.chk_data) chk({tag, "_wb_data"}, Write_data_WB, e.data);
            chk({tag, "_wb_reg"}, {27'd0, Write_register_WB}, {27'd0, e.rd});
            chk({tag, "_wb_rw"}, {31'd0, RegWrite_WB}, {31'd0, e.rw});
        end
    endtask

    task automatic set_nop();
        ALU_result_MEM = 0; Read_Data_2_MEM = 0; MemRead_MEM = 0; MemWrite_MEM = 0;
        MemToReg_MEM = 0; RegWrite_MEM = 0; Branch_MEM = 0; Zero_MEM = 0;
        Write_register_MEM = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // ack_after: REQ cycle number (1-based) in which ack is driven; 0 = never.
    task automatic mem_op(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic is_load, input int ack_after, input logic [31:0] rdata,
                          input logic [4:0] rd, input int exp_stalls, input int exp_nreq,
                          input logic [31:0] exp_data, input logic exp_rw);
        int  nreq = 0;
        int  stalls = 0;
        bit  done = 0;
        ALU_result_MEM = addr; Read_Data_2_MEM = wd; MemRead_MEM = is_load;
        MemWrite_MEM = ~is_load; MemToReg_MEM = is_load; RegWrite_MEM = is_load;
        Write_register_MEM = rd;
        sb.push_back('{exp_data, rd, exp_rw, 1'b1});
        for (int c = 0; c < 64 && !done; c++) begin
            #1;
            if (dmem_req) begin
                nreq++;
                chk({tag, "_addr"}, dmem_addr, addr);
                chk({tag, "_wdata"}, dmem_wdata, wd);
                chk({tag, "_we"}, {31'd0, dmem_we}, {31'd0, ~is_load});
                if (nreq == ack_after) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            if (stall_MEM) stalls++;
            else done = 1;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
            dmem_rdata = 32'h0;
            if (!done) chk({tag, "_bubble"}, {31'd0, RegWrite_WB}, 32'd0);
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: stall never released, got %0d want %0d cycles", tag, stalls, exp_stalls);
        end
        set_nop();
        chk({tag, "_stalls"}, stalls, exp_stalls);
        chk({tag, "_nreq"}, nreq, exp_nreq);
        chk({tag, "_req_off"}, {31'd0, dmem_req}, 32'd0);
        sb_pop(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //             alu           rd wr m2r rw br z  rd  pc al rw chk
        tbl[0] = '{32'h0000_0007, 0, 0, 0, 1, 0, 0, 5'd3,  0, 0, 1, 1};
        tbl[1] = '{32'h0000_0000, 0, 0, 0, 0, 1, 1, 5'd0,  1, 0, 0, 1};
        tbl[2] = '{32'h0000_0005, 0, 0, 0, 0, 1, 0, 5'd0,  0, 0, 0, 1};
        tbl[3] = '{32'h0000_0013, 1, 0, 1, 1, 0, 0, 5'd5,  0, 1, 0, 0};
        tbl[4] = '{32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 5'd31, 0, 0, 1, 1};
        tbl[5] = '{32'h0000_0022, 0, 1, 0, 0, 0, 0, 5'd7,  0, 1, 0, 1};
        tbl[6] = '{32'h8000_0000, 0, 0, 0, 0, 0, 0, 5'd1,  0, 0, 0, 1};

        set_nop();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_data", Write_data_WB, 32'd0);
        chk("rst_wb_reg", {27'd0, Write_register_WB}, 32'd0);
        chk("rst_wb_rw", {31'd0, RegWrite_WB}, 32'd0);
        chk("rst_align", {31'd0, align_err}, 32'd0);
        chk("rst_bus", {31'd0, bus_err}, 32'd0);
        reset = 1'b0;

        // Single-cycle ops; ack is toggled on odd entries and must be ignored outside REQ.
        for (int i = 0; i < 7; i++) begin
            ALU_result_MEM = tbl[i].alu; MemRead_MEM = tbl[i].mrd; MemWrite_MEM = tbl[i].mwr;
            MemToReg_MEM = tbl[i].m2r; RegWrite_MEM = tbl[i].rw; Branch_MEM = tbl[i].br;
            Zero_MEM = tbl[i].zero; Write_register_MEM = tbl[i].rd; Read_Data_2_MEM = 32'hA5A5_0000;
            dmem_ack = i[0]; dmem_rdata = 32'hBAD0_BAD0;
            sb.push_back('{tbl[i].alu, tbl[i].rd, tbl[i].exp_rw, tbl[i].chk_data});
            #1;
            chk($sformatf("v%0d_stall", i), {31'd0, stall_MEM}, 32'd0);
            chk($sformatf("v%0d_pcsrc", i), {31'd0, PCSrc_MEM}, {31'd0, tbl[i].exp_pcsrc});
            @(posedge clk); #1;
            chk($sformatf("v%0d_align", i), {31'd0, align_err}, {31'd0, tbl[i].exp_align});
            chk($sformatf("v%0d_req", i), {31'd0, dmem_req}, 32'd0);
            sb_pop($sformatf("v%0d", i));
        end
        set_nop();
        @(posedge clk); #1;
        chk("align_clear", {31'd0, align_err}, 32'd0);

        mem_op("load", 32'h10, 32'h0, 1'b1, 1, 32'hDEAD_BEEF, 5'd5, 2, 1, 32'hDEAD_BEEF, 1'b1);
        mem_op("store", 32'h20, 32'h1234_5678, 1'b0, 4, 32'h0, 5'd9, 5, 4, 32'h20, 1'b0);
        mem_op("load2", 32'h44, 32'h0, 1'b1, 2, 32'h0BAD_F00D, 5'd12, 3, 2, 32'h0BAD_F00D, 1'b1);

`ifdef MEM_TIMEOUT_EN
        mem_op("tmo", 32'h80, 32'h0, 1'b1, 0, 32'h0, 5'd6, 5, 4, 32'h0, 1'b0);
        chk("tmo_bus", {31'd0, bus_err}, 32'd1);
        @(posedge clk); #1;
        chk("tmo_bus_sticky", {31'd0, bus_err}, 32'd1);
`else
        chk("bus_tied", {31'd0, bus_err}, 32'd0);
`endif

        // Reset while a request is outstanding.
        ALU_result_MEM = 32'h40; MemRead_MEM = 1'b1; MemToReg_MEM = 1'b1; RegWrite_MEM = 1'b1;
        Write_register_MEM = 5'd4;
        @(posedge clk); #1;
        chk("rmid_req_on", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        set_nop();
        @(posedge clk); #1;
        chk("rmid_req_off", {31'd0, dmem_req}, 32'd0);
        chk("rmid_bus", {31'd0, bus_err}, 32'd0);
        chk("rmid_wb_data", Write_data_WB, 32'd0);
        reset = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
        #1;
        chk("rmid_stall", {31'd0, stall_MEM}, 32'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("rmid_late_ack_req", {31'd0, dmem_req}, 32'd0);
        chk("rmid_late_ack_rw", {31'd0, RegWrite_WB}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
